cache_mem_arbiter: RTL

Two-port arbiter between the instruction cache and data cache memory-side ports and the single off-chip memory interface. Each cache's memory port connects to this block with the same valid/ready request, data, and response signalling. The block forwards one cache's transaction at a time to memory. It holds ownership across a multi-beat refill and routes response beats back to the owning cache.

---
 rtl/cache_mem_arbiter_pkg.sv | 19 +
 rtl/cache_mem_arbiter_rr_arb2.sv | 14 +
 rtl/cache_mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I$/D$ to off-chip memory arbiter.
// Holds the FSM state encoding, the port IDs and the beat counter width helper.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WDATA = 2'd1,
    ARB_READ  = 2'd2
  } arb_state_e;

  localparam logic ARB_IC = 1'b0;
  localparam logic ARB_DC = 1'b1;

  // A single-beat configuration still needs a 1-bit counter.
  function automatic int beat_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. A lone requester wins outright.
// On a tie, the port that was not served last wins.
module rr_arb2
  import cache_mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | (last == ARB_DC));
  assign grant[1] = valid[1] & (~valid[0] | (last == ARB_IC));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I$ (port 0) and D$ (port 1) memory ports onto one memory interface.
// The owning port is held across a write-data wait or a multi-beat read refill.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter  int ADDR_BITS  = 28,
  parameter  int DATA_BITS  = 128,
  parameter  int RESP_BEATS = 4,
  localparam int BEAT_W     = beat_bits(RESP_BEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]   ic_mem_resp_data,
  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   dc_mem_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [1:0]             dbg_state,
  output logic [BEAT_W-1:0]      dbg_beat
);

  // Handshake: a channel transfers on a cycle where valid & ready are both 1.
  // Ready may depend combinationally on valid; valid never waits on ready.

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RESP_BEATS - 1);

  arb_state_e        state, state_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic [BEAT_W-1:0] beat, beat_n;

  logic [1:0] req_valid, grant, req_ready, data_ready, resp_valid;
  logic       sel, sel_req_valid, sel_data_valid, req_fire, data_fire;

  assign req_valid = {dc_mem_req_valid, ic_mem_req_valid};

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .last  (last),
    .grant (grant)
  );

  // In WDATA the owner keeps the channel; otherwise the current tie-winner drives it.
  assign sel            = (state == ARB_WDATA) ? owner : grant[1];
  assign sel_req_valid  = sel ? dc_mem_req_valid      : ic_mem_req_valid;
  assign sel_data_valid = sel ? dc_mem_req_data_valid : ic_mem_req_data_valid;

  assign mem_req_addr      = sel ? dc_mem_req_addr      : ic_mem_req_addr;
  assign mem_req_rw        = sel ? dc_mem_req_rw        : ic_mem_req_rw;
  assign mem_req_data_bits = sel ? dc_mem_req_data_bits : ic_mem_req_data_bits;
  assign mem_req_data_mask = sel ? dc_mem_req_data_mask : ic_mem_req_data_mask;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign data_fire = mem_req_data_valid & mem_req_data_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_IDLE;
      owner <= ARB_IC;
      last  <= ARB_IC;
      beat  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n            = state;
    owner_n            = owner;
    last_n             = last;
    beat_n             = beat;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    req_ready          = 2'b00;
    data_ready         = 2'b00;
    resp_valid         = 2'b00;
    if (reset) begin
      unique case (state)
        ARB_IDLE: begin
          if (|grant) begin
            mem_req_valid      = sel_req_valid;
            mem_req_data_valid = sel_data_valid;
            req_ready[sel]     = mem_req_ready;
            data_ready[sel]    = mem_req_data_ready;
          end
          if (req_fire) begin
            if (!mem_req_rw) begin
              owner_n = sel;
              last_n  = sel;
              beat_n  = '0;
              state_n = ARB_READ;
            end else if (data_fire) begin
              last_n = sel;
            end else begin
              owner_n = sel;
              state_n = ARB_WDATA;
            end
          end
        end
        ARB_WDATA: begin
          mem_req_data_valid = sel_data_valid;
          data_ready[sel]    = mem_req_data_ready;
          if (data_fire) begin
            last_n  = owner;
            state_n = ARB_IDLE;
          end
        end
        ARB_READ: begin
          resp_valid[owner] = mem_resp_valid;
          if (mem_resp_valid) begin
            if (beat == BEAT_LAST) begin
              beat_n  = '0;
              state_n = ARB_IDLE;
            end else begin
              beat_n = beat + 1'b1;
            end
          end
        end
        default: state_n = ARB_IDLE;
      endcase
    end
  end

  assign ic_mem_req_ready      = req_ready[0];
  assign dc_mem_req_ready      = req_ready[1];
  assign ic_mem_req_data_ready = data_ready[0];
  assign dc_mem_req_data_ready = data_ready[1];
  assign ic_mem_resp_valid     = resp_valid[0];
  assign dc_mem_resp_valid     = resp_valid[1];
  assign ic_mem_resp_data      = mem_resp_data;
  assign dc_mem_resp_data      = mem_resp_data;

  assign dbg_state = state;
  assign dbg_beat  = beat;

endmodule
